// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB requester with valid/ready command and response ports.
// An ACCESS-phase timeout turns a hung slave into an error response.
module apb_master_bridge #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);
  // Width floors at 1 so TIMEOUT=0 still elaborates; the counter is then never compared.
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic              timed_out;
  assign timed_out   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign cmd_ready_o = state_q == IDLE;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rsp_err_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d  = SETUP;
        psel_d   = 1'b1;
        pwrite_d = cmd_write_i;
        paddr_d  = cmd_addr_i;
        pwdata_d = cmd_wdata_i;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (pready_i || timed_out) begin
        state_d     = RESP;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !pready_i;
        rdata_d     = (pready_i && !pwrite_q) ? prdata_i : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        cnt_d       = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized scoreboard bench with a memory-backed APB slave model
// and a second bridge instance built with the timeout disabled.
module tb_apb_master_bridge;
  logic        clk = 0, reset = 1;
  logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 1, pready = 0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, prdata = '0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o;
  logic [31:0] rsp_rdata_o, pwdata_o;
  logic [9:0]  paddr_o;
  logic        cv2 = 0, crdy2, rv2, err2, psel2, pen2, pwr2;
  logic [31:0] rd2, pwd2;
  logic [9:0]  pa2;
  int          n_cmp = 0, n_bad = 0, acc2 = 0;
  logic [32:0] exp_q[$];
  int          dly_q[$];
  logic [31:0] ref_mem[int], slave_mem[int];

  apb_master_bridge #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready));

  apb_master_bridge #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(0)) dut_t0 (
    .clk(clk), .reset(reset), .cmd_valid_i(cv2), .cmd_ready_o(crdy2),
    .cmd_write_i(1'b0), .cmd_addr_i(10'h001), .cmd_wdata_i(32'h0),
    .rsp_valid_o(rv2), .rsp_ready_i(1'b1), .rsp_rdata_o(rd2),
    .rsp_err_o(err2), .psel_o(psel2), .penable_o(pen2), .paddr_o(pa2),
    .pwrite_o(pwr2), .pwdata_o(pwd2), .prdata_i(32'h0), .pready_i(1'b0));

  always #5 clk = ~clk;

  // Slave model: delay per transfer taken at SETUP; -1 means never respond.
  initial begin
    int cur;
    cur = 0;
    forever begin
      @(posedge clk); #1;
      pready = 0;
      if (psel_o && !penable_o) cur = dly_q.size() > 0 ? dly_q.pop_front() : 0;
      else if (psel_o && penable_o) begin
        if (cur == 0) begin
          pready = 1;
          prdata = slave_mem.exists(int'(paddr_o)) ? slave_mem[int'(paddr_o)] : 32'h0;
          if (pwrite_o) slave_mem[int'(paddr_o)] = pwdata_o;
        end else if (cur > 0) cur--;
      end
    end
  end

  always @(negedge clk) begin : rsp_mon
    logic [32:0] e;
    if (!reset && rsp_valid_o && rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got err=%b rdata=%h expected no response", rsp_err_o, rsp_rdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_err_o, rsp_rdata_o} !== e) begin
          n_bad++;
          $display("FAIL rsp_data: got err=%b rdata=%h expected err=%b rdata=%h", rsp_err_o, rsp_rdata_o, e[32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin : proto_mon
    static logic       pp = 0, pw = 0;
    static logic [9:0]  pa = '0;
    static logic [31:0] pd = '0;
    if (!reset) begin
      n_cmp++;
      if (penable_o && !psel_o) begin
        n_bad++;
        $display("FAIL penable_without_psel: got psel=%b penable=%b expected psel=1", psel_o, penable_o);
      end else if (psel_o && penable_o && (!pp || paddr_o !== pa || pwdata_o !== pd || pwrite_o !== pw)) begin
        n_bad++;
        $display("FAIL access_stable: got addr=%h data=%h wr=%b prev_psel=%b expected addr=%h data=%h wr=%b prev_psel=1",
                 paddr_o, pwdata_o, pwrite_o, pp, pa, pd, pw);
      end
    end
    pp = psel_o && !reset; pa = paddr_o; pd = pwdata_o; pw = pwrite_o;
    if (psel2 && pen2) acc2++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic start(input bit w, input logic [9:0] a, input logic [31:0] d, input int dly);
    logic [31:0] r;
    r = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    if (dly < 0) exp_q.push_back({1'b1, 32'h0});
    else if (w) begin
      ref_mem[int'(a)] = d;
      exp_q.push_back(33'h0);
    end else exp_q.push_back({1'b0, r});
    dly_q.push_back(dly);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready_o && n < 1000);
    if (!cmd_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 1000 cycles");
    end
    sync();
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid_o && n < 1000);
    if (!rsp_valid_o) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 1000 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [31:0] hr;
    logic        he;
    @(negedge clk);
    chk("reset_outputs", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, paddr_o, pwdata_o, rsp_rdata_o},
        64'h0);
    chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    sync(); reset = 0;
    cv2 = 1; sync(); cv2 = 0;
    // Write/read 0x005 with varied slave delays.
    for (int i = 0; i < 4; i++) begin
      start(1, 10'h005, 32'hDEADBEEF, int'($urandom_range(0, 15))); wait_accept(); cmd_valid = 0;
      start(0, 10'h005, 32'h0, int'($urandom_range(0, 15))); wait_accept(); cmd_valid = 0;
    end
    drain();
    // Cycle-exact latency with pready immediate and rsp_ready high.
    sync();
    start(0, 10'h005, 32'h0, 0); wait_accept(); cmd_valid = 0;
    @(negedge clk); chk("lat_setup", {cmd_ready_o, psel_o, penable_o, rsp_valid_o}, 64'b0100);
    @(negedge clk); chk("lat_access", {cmd_ready_o, psel_o, penable_o, rsp_valid_o}, 64'b0110);
    @(negedge clk); chk("lat_resp", {cmd_ready_o, psel_o, penable_o, rsp_valid_o}, 64'b0001);
    @(negedge clk); chk("lat_idle", {cmd_ready_o, psel_o, penable_o, rsp_valid_o}, 64'b1000);
    // Hung slave aborts after exactly 64 ACCESS cycles.
    sync();
    start(1, 10'h020, 32'h11112222, -1); wait_accept(); cmd_valid = 0;
    cnt = 0;
    for (int i = 0; i < 300 && !rsp_valid_o; i++) begin
      @(negedge clk);
      if (psel_o && penable_o) cnt++;
    end
    chk("timeout_cycles", 64'(cnt), 64'd64);
    chk("timeout_bus_idle", {psel_o, penable_o, rsp_err_o, rsp_rdata_o}, {3'b001, 32'h0});
    drain();
    chk("t0_stuck_in_access", {psel2, pen2, rv2}, 64'b110);
    chk("t0_access_cycles_gt_100", 64'(acc2 > 100), 64'd1);
    // Response held while rsp_ready is low; a pending command waits for the handshake.
    sync(); rsp_ready = 0;
    start(0, 10'h005, 32'h0, 2); wait_accept(); cmd_valid = 0;
    wait_rsp();
    hr = rsp_rdata_o; he = rsp_err_o;
    sync();
    start(1, 10'h006, 32'h12345678, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid_o, rsp_err_o, cmd_ready_o, psel_o, rsp_rdata_o}, {1'b1, he, 2'b00, hr});
    end
    sync(); rsp_ready = 1;
    wait_accept(); cmd_valid = 0;
    drain();
    // Reset during ACCESS drops the bus immediately; next read completes normally.
    sync();
    start(1, 10'h3FF, 32'hA5A55A5A, 3); wait_accept(); cmd_valid = 0;
    drain();
    sync();
    start(0, 10'h010, 32'h0, -1); wait_accept(); cmd_valid = 0;
    for (int i = 0; i < 20 && !(psel_o && penable_o); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1 chk("reset_mid_access", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, paddr_o, pwdata_o, rsp_rdata_o},
           64'h0);
    exp_q.delete();
    sync(); reset = 0;
    start(0, 10'h3FF, 32'h0, 2); wait_accept(); cmd_valid = 0;
    drain();
    // Back-to-back random traffic with cmd_valid held high.
    sync();
    for (int i = 0; i < 100; i++) begin
      start(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 15)));
      wait_accept();
    end
    cmd_valid = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
